// File: rtl/pipeline_hazard_controller_pkg.sv
// ============================================================================
// hazard_ctrl_pkg : shared types and encodings for the pipeline hazard
// controller and its statistics counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;

  localparam int STALL_CNT_W = 2;

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_controller_stat_counter.sv
// ============================================================================
// hazard_stat_counter : 16-bit event counter that sticks at all-ones.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_stat_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
// ============================================================================
// pipeline_hazard_controller : prioritised stall/flush sequencer for the
// five-stage pipeline. Optional macro HAZARD_STATS_EN adds event counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_controller
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W        = 3,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_busy,
  input  logic                  branch_taken,
  input  logic                  uncond_jump,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  id_ex_write_en,
  output logic                  ex_mem_write_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic [1:0]            pc_sel,
`ifdef HAZARD_STATS_EN
  output logic [15:0]           stall_count,
  output logic [15:0]           flush_count,
`endif
  output logic                  stall_active
);

  // The load cycle itself is the first bubble, so STALL covers the remainder.
  localparam logic [STALL_CNT_W-1:0] C_STALL_INIT =
    STALL_CNT_W'((LOAD_STALL_CYCLES > 1) ? (LOAD_STALL_CYCLES - 2) : 0);

  state_e                 state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   w_lu;
  logic                   w_stall_evt;

  assign w_lu = ex_mem_read &&
                ((id_rs1_used && (id_rs1 == ex_rd)) ||
                 (id_rs2_used && (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    stall_cnt_d     = stall_cnt_q;
    pc_write_en     = 1'b1;
    if_id_write_en  = 1'b1;
    id_ex_write_en  = 1'b1;
    ex_mem_write_en = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    pc_sel          = PC_SEQ;
    w_stall_evt     = 1'b0;

    if (rst) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      state_d         = ST_RUN;
      stall_cnt_d     = '0;
    end else if (mem_busy) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
    end else if (branch_taken) begin
      pc_sel      = PC_BRANCH;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = ST_RUN;
      stall_cnt_d = '0;
    end else if ((state_q == ST_STALL) || w_lu) begin
      // A jump sitting behind a bubble stays in ID and redirects afterwards.
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_flush    = 1'b1;
      w_stall_evt    = 1'b1;
      if (state_q == ST_STALL) begin
        if (stall_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          stall_cnt_d = stall_cnt_q - 1'b1;
        end
      end else if (LOAD_STALL_CYCLES > 1) begin
        state_d     = ST_STALL;
        stall_cnt_d = C_STALL_INIT;
      end
    end else if (uncond_jump) begin
      pc_sel      = PC_JUMP;
      if_id_flush = 1'b1;
    end
  end

  assign stall_active = !rst && (state_q == ST_STALL);

`ifdef HAZARD_STATS_EN
  hazard_stat_counter u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (w_stall_evt),
    .count_o (stall_count)
  );

  hazard_stat_counter u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (if_id_flush),
    .count_o (flush_count)
  );
`else
  logic w_unused;
  assign w_unused = w_stall_evt;
`endif

endmodule

`default_nettype wire
